// File: rtl/mux_valve_sequencer.sv
// Break-before-make valve sequencer for a binary-tree fluidic multiplexer.
// Every valve closes and settles before the newly selected path opens and settles.
module mux_valve_sequencer #(
  parameter int LEVELS       = 2,
  parameter int CLOSE_CYCLES = 4,
  parameter int OPEN_CYCLES  = 8,
  parameter int CNT_W        = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic [LEVELS-1:0] i_req_chan,
  output logic              o_req_ready,
  input  logic              i_release,
  output logic [LEVELS-1:0] o_ctrl_0,
  output logic [LEVELS-1:0] o_ctrl_1,
  output logic              o_path_open,
  output logic [LEVELS-1:0] o_cur_chan,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLOSE,
    S_OPEN,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] CLOSE_LOAD = CNT_W'(CLOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OPEN_LOAD  = CNT_W'(OPEN_CYCLES - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [LEVELS-1:0] r_cur_chan;
  logic [LEVELS-1:0] r_ctrl_0;
  logic [LEVELS-1:0] r_ctrl_1;
  logic              r_path_open;
  logic              r_req_ready;
  logic              r_busy;

  state_t            w_state_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [LEVELS-1:0] w_chan_next;
  logic [LEVELS-1:0] w_path_0;
  logic [LEVELS-1:0] w_path_1;
  logic [LEVELS-1:0] w_ctrl_0_next;
  logic [LEVELS-1:0] w_ctrl_1_next;
  logic              w_accept;
  logic              w_drive;

  assign w_accept = i_req_valid & r_req_ready;

  // Level gi+1 is steered by channel bit LEVELS-1-gi, so the root level uses the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_decode
      assign w_path_0[gi] = w_chan_next[LEVELS-1-gi];
      assign w_path_1[gi] = ~w_chan_next[LEVELS-1-gi];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_chan_next  = r_cur_chan;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_chan_next  = i_req_chan;
          w_cnt_next   = CLOSE_LOAD;
          w_state_next = S_CLOSE;
        end
      end
      S_CLOSE: begin
        if (r_cnt == '0) begin
          w_cnt_next   = OPEN_LOAD;
          w_state_next = S_OPEN;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_OPEN: begin
        if (r_cnt == '0) begin
          w_state_next = S_HOLD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        // A request beats a simultaneous release; a same-channel request is a no-op.
        if (w_accept) begin
          if (i_req_chan != r_cur_chan) begin
            w_chan_next  = i_req_chan;
            w_cnt_next   = CLOSE_LOAD;
            w_state_next = S_CLOSE;
          end
        end else if (i_release) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    w_drive       = (w_state_next == S_OPEN) || (w_state_next == S_HOLD);
    w_ctrl_0_next = w_drive ? w_path_0 : '1;
    w_ctrl_1_next = w_drive ? w_path_1 : '1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cur_chan  <= '0;
      r_ctrl_0    <= '1;
      r_ctrl_1    <= '1;
      r_path_open <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_cur_chan  <= w_chan_next;
      r_ctrl_0    <= w_ctrl_0_next;
      r_ctrl_1    <= w_ctrl_1_next;
      r_path_open <= (w_state_next == S_HOLD);
      r_req_ready <= (w_state_next == S_IDLE) || (w_state_next == S_HOLD);
      r_busy      <= (w_state_next == S_CLOSE) || (w_state_next == S_OPEN);
    end
  end

  assign o_ctrl_0    = r_ctrl_0;
  assign o_ctrl_1    = r_ctrl_1;
  assign o_path_open = r_path_open;
  assign o_req_ready = r_req_ready;
  assign o_cur_chan  = r_cur_chan;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_mux_valve_sequencer.sv
// Directed bench for mux_valve_sequencer with LEVELS=2, CLOSE_CYCLES=4, OPEN_CYCLES=8.
module tb_mux_valve_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_chan;
  logic       req_ready;
  logic       rel;
  logic [1:0] ctrl_0;
  logic [1:0] ctrl_1;
  logic       path_open;
  logic [1:0] cur_chan;
  logic       busy;

  int errors = 0;
  int checks = 0;
  bit inv_en = 0;

  mux_valve_sequencer #(
    .LEVELS(2), .CLOSE_CYCLES(4), .OPEN_CYCLES(8), .CNT_W(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_chan(req_chan),
    .o_req_ready(req_ready), .i_release(rel), .o_ctrl_0(ctrl_0), .o_ctrl_1(ctrl_1),
    .o_path_open(path_open), .o_cur_chan(cur_chan), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // No level may ever have both branches vented.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if ((ctrl_0 | ctrl_1) !== 2'b11) begin
        errors++;
        $display("FAIL invariant t=%0t ctrl_0=%b ctrl_1=%b required (ctrl_0|ctrl_1)=11", $time, ctrl_0, ctrl_1);
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; req_valid = 1'b0; req_chan = 2'd0; rel = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl_0 !== 2'b11 || ctrl_1 !== 2'b11 || path_open !== 1'b0 || req_ready !== 1'b1 ||
        busy !== 1'b0 || cur_chan !== 2'd0) begin
      errors++;
      $display("FAIL reset_async ctrl_0=%b ctrl_1=%b open=%b ready=%b busy=%b chan=%0d required 11 11 0 1 0 0",
               ctrl_0, ctrl_1, path_open, req_ready, busy, cur_chan);
    end
    $display("reset asserted mid-clock: ctrl_0=%b ctrl_1=%b", ctrl_0, ctrl_1);
    inv_en = 1;
    wait_edges(2);
    #3 rst_n = 1'b1;
    wait_edges(3);
    checks++;
    if (ctrl_0 !== 2'b11 || ctrl_1 !== 2'b11 || path_open !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold ctrl_0=%b ctrl_1=%b open=%b ready=%b busy=%b required 11 11 0 1 0",
               ctrl_0, ctrl_1, path_open, req_ready, busy);
    end
    // release while idle must be ignored
    rel = 1'b1;
    wait_edges(2);
    rel = 1'b0;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || ctrl_0 !== 2'b11 || ctrl_1 !== 2'b11) begin
      errors++;
      $display("FAIL release_idle busy=%b ready=%b ctrl_0=%b ctrl_1=%b required 0 1 11 11",
               busy, req_ready, ctrl_0, ctrl_1);
    end
  endtask

  task automatic test_single_route;
    req_valid = 1'b1; req_chan = 2'd2;
    wait_edges(1);
    req_valid = 1'b0;
    $display("accept chan=2");
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) begin
        // ignored: release outside HOLD, and a request while not ready
        rel = 1'b1; req_valid = 1'b1; req_chan = 2'd3;
      end
      if (k == 3) begin
        rel = 1'b0; req_valid = 1'b0;
      end
      checks++;
      if (busy !== 1'b1 || ctrl_0 !== 2'b11 || ctrl_1 !== 2'b11 || req_ready !== 1'b0 ||
          path_open !== 1'b0 || cur_chan !== 2'd2) begin
        errors++;
        $display("FAIL route2_close T+%0d busy=%b ctrl_0=%b ctrl_1=%b ready=%b open=%b chan=%0d required 1 11 11 0 0 2",
                 k, busy, ctrl_0, ctrl_1, req_ready, path_open, cur_chan);
      end
      wait_edges(1);
    end
    for (int k = 5; k <= 12; k++) begin
      checks++;
      if (ctrl_0 !== 2'b01 || ctrl_1 !== 2'b10 || path_open !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL route2_open T+%0d ctrl_0=%b ctrl_1=%b open=%b busy=%b required 01 10 0 1",
                 k, ctrl_0, ctrl_1, path_open, busy);
      end
      wait_edges(1);
    end
    checks++;
    if (path_open !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0 || cur_chan !== 2'd2 ||
        ctrl_0 !== 2'b01 || ctrl_1 !== 2'b10) begin
      errors++;
      $display("FAIL route2_hold open=%b ready=%b busy=%b chan=%0d ctrl_0=%b ctrl_1=%b required 1 1 0 2 01 10",
               path_open, req_ready, busy, cur_chan, ctrl_0, ctrl_1);
    end
    $display("route chan=2 holding: ctrl_0=%b ctrl_1=%b open=%b", ctrl_0, ctrl_1, path_open);
  endtask

  task automatic test_reroute;
    req_valid = 1'b1; req_chan = 2'd1;
    wait_edges(1);
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (path_open !== 1'b0 || ctrl_0 !== 2'b11 || ctrl_1 !== 2'b11 || busy !== 1'b1 || cur_chan !== 2'd1) begin
        errors++;
        $display("FAIL reroute_close T+%0d open=%b ctrl_0=%b ctrl_1=%b busy=%b chan=%0d required 0 11 11 1 1",
                 k, path_open, ctrl_0, ctrl_1, busy, cur_chan);
      end
      wait_edges(1);
    end
    for (int k = 5; k <= 12; k++) begin
      checks++;
      if (ctrl_0 !== 2'b10 || ctrl_1 !== 2'b01 || path_open !== 1'b0) begin
        errors++;
        $display("FAIL reroute_open T+%0d ctrl_0=%b ctrl_1=%b open=%b required 10 01 0",
                 k, ctrl_0, ctrl_1, path_open);
      end
      wait_edges(1);
    end
    checks++;
    if (path_open !== 1'b1 || ctrl_0 !== 2'b10 || ctrl_1 !== 2'b01) begin
      errors++;
      $display("FAIL reroute_hold open=%b ctrl_0=%b ctrl_1=%b required 1 10 01", path_open, ctrl_0, ctrl_1);
    end
    $display("reroute to chan=1 holding: ctrl_0=%b ctrl_1=%b", ctrl_0, ctrl_1);
  endtask

  task automatic test_same_channel;
    req_valid = 1'b1; req_chan = 2'd3;
    wait_edges(1);
    req_valid = 1'b0;
    wait_edges(12);
    checks++;
    if (path_open !== 1'b1 || ctrl_0 !== 2'b11 || ctrl_1 !== 2'b00 || cur_chan !== 2'd3) begin
      errors++;
      $display("FAIL route3_hold open=%b ctrl_0=%b ctrl_1=%b chan=%0d required 1 11 00 3",
               path_open, ctrl_0, ctrl_1, cur_chan);
    end
    req_valid = 1'b1; req_chan = 2'd3;
    for (int k = 1; k <= 4; k++) begin
      wait_edges(1);
      req_valid = 1'b0;
      checks++;
      if (path_open !== 1'b1 || ctrl_0 !== 2'b11 || ctrl_1 !== 2'b00 || busy !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL same_chan T+%0d open=%b ctrl_0=%b ctrl_1=%b busy=%b ready=%b required 1 11 00 0 1",
                 k, path_open, ctrl_0, ctrl_1, busy, req_ready);
      end
    end
    $display("same-channel re-request chan=3: open=%b", path_open);
  endtask

  task automatic test_release_collision;
    rel = 1'b1; req_valid = 1'b1; req_chan = 2'd0;
    wait_edges(1);
    rel = 1'b0; req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || path_open !== 1'b0 || cur_chan !== 2'd0 || ctrl_0 !== 2'b11 || ctrl_1 !== 2'b11) begin
      errors++;
      $display("FAIL collision busy=%b open=%b chan=%0d ctrl_0=%b ctrl_1=%b required 1 0 0 11 11",
               busy, path_open, cur_chan, ctrl_0, ctrl_1);
    end
    wait_edges(12);
    checks++;
    if (path_open !== 1'b1 || ctrl_0 !== 2'b00 || ctrl_1 !== 2'b11) begin
      errors++;
      $display("FAIL route0_hold open=%b ctrl_0=%b ctrl_1=%b required 1 00 11", path_open, ctrl_0, ctrl_1);
    end
    rel = 1'b1;
    wait_edges(1);
    rel = 1'b0;
    checks++;
    if (ctrl_0 !== 2'b11 || ctrl_1 !== 2'b11 || path_open !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL release ctrl_0=%b ctrl_1=%b open=%b busy=%b ready=%b required 11 11 0 0 1",
               ctrl_0, ctrl_1, path_open, busy, req_ready);
    end
    $display("collision then release: idle ctrl_0=%b ctrl_1=%b", ctrl_0, ctrl_1);
  endtask

  task automatic test_reset_during_open;
    req_valid = 1'b1; req_chan = 2'd2;
    wait_edges(1);
    req_valid = 1'b0;
    wait_edges(6);
    checks++;
    if (ctrl_0 !== 2'b01 || ctrl_1 !== 2'b10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_open ctrl_0=%b ctrl_1=%b busy=%b required 01 10 1", ctrl_0, ctrl_1, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl_0 !== 2'b11 || ctrl_1 !== 2'b11 || path_open !== 1'b0 || busy !== 1'b0 ||
        req_ready !== 1'b1 || cur_chan !== 2'd0) begin
      errors++;
      $display("FAIL reset_open ctrl_0=%b ctrl_1=%b open=%b busy=%b ready=%b chan=%0d required 11 11 0 0 1 0",
               ctrl_0, ctrl_1, path_open, busy, req_ready, cur_chan);
    end
    rst_n = 1'b1;
    wait_edges(3);
    checks++;
    if (ctrl_0 !== 2'b11 || ctrl_1 !== 2'b11 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_open_idle ctrl_0=%b ctrl_1=%b busy=%b ready=%b required 11 11 0 1",
               ctrl_0, ctrl_1, busy, req_ready);
    end
    $display("reset during OPEN: ctrl_0=%b ctrl_1=%b busy=%b", ctrl_0, ctrl_1, busy);
  endtask

  initial begin
    test_reset();
    test_single_route();
    test_reroute();
    test_same_channel();
    test_release_collision();
    test_reset_during_open();
    inv_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
